rx_lane_merger: RTL and testbench
=================================

RX_LANE_MERGER -- requirements
Module: rx_lane_merger

Interface
REQ-001 Parameter: DEPTH, 4, per-lane FIFO depth in bytes; power of two, 2 or greater.
REQ-002 Parameter: W, 8, lane data width in bits.
REQ-003 Port: clk_f  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: data_rx0..data_rx3  input  W each  lane bytes from the demux stage.
REQ-006 Port: valid_rx0..valid_rx3  input  1 each  lane byte qualifiers.
REQ-007 Port: ready_in  input  1  downstream accepts data_out this cycle.
REQ-008 Port: data_out  output  W  merged byte stream, registered.
REQ-009 Port: valid_out  output  1  data_out holds a byte, registered.
REQ-010 Port: lane_out  output  2  source lane of the current data_out, registered.
REQ-011 Port: lanes_empty  output  4  bit N high when FIFO N holds zero bytes.

Function
REQ-012 The block SHALL keep one FIFO per lane, DEPTH entries of W bits each, with wrap-around read and write pointers and an occupancy counter.
REQ-013 On an edge with valid_rxN high, FIFO N SHALL accept data_rxN unless it is full and is not popped on the same edge.
REQ-014 A full FIFO that is popped on the same edge SHALL accept the write, so occupancy stays at DEPTH.
REQ-015 Bytes that are not accepted SHALL be dropped without any effect on other lanes.
REQ-016 The output register SHALL load when valid_out is low or ready_in is high.
REQ-017 When the output register loads and at least one FIFO is non-empty, the block SHALL pop the granted FIFO, drive its head byte and lane index, and set valid_out.
REQ-018 When the output register loads and all FIFOs are empty, valid_out SHALL go low.
REQ-019 Grant SHALL be round-robin: search starts at the lane after last_grant, wrapping 3->0; last_grant updates only on a pop.
REQ-020 While valid_out is high and ready_in is low, data_out, lane_out and valid_out SHALL hold, and no FIFO SHALL be popped.
REQ-021 Latency: a byte written into an empty FIFO at edge k, with the output register free, SHALL appear on data_out after edge k+1.
REQ-022 With ready_in held high and traffic waiting, the block SHALL sustain one byte per clock.
REQ-023 Within a lane, byte order SHALL be preserved.
REQ-024 lanes_empty SHALL be derived from the registered occupancy counters.

Reset
REQ-025 While reset is high, the block SHALL asynchronously clear data_out to 0, valid_out to 0 and lane_out to 0.
REQ-026 While reset is high, all FIFO pointers and counters SHALL clear to 0, lanes_empty SHALL read 4'b1111, and last_grant SHALL be 3 so lane 0 has first priority.
REQ-027 Reset asserted mid-transfer SHALL discard all buffered bytes and the held output byte.
REQ-028 Inputs on the first edge after reset deasserts SHALL be accepted normally.

Configuration
REQ-029 With macro MERGE_OVERFLOW_FLAG_EN defined, the block SHALL add output port ovf_lanes (4 bits, registered); bit N sets sticky on any byte dropped by REQ-013 and clears only on reset.
REQ-030 Without MERGE_OVERFLOW_FLAG_EN, the ovf_lanes port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Scenario: after reset, one edge with rx0=FFh, rx1=DDh, rx2=EEh, rx3=CCh, all valid, ready_in=1 -> data_out FFh, DDh, EEh, CCh on consecutive cycles, with lane_out 0,1,2,3.
REQ-032 Scenario: ready_in=0 and lane 0 valid for 6 consecutive edges with bytes 01h..06h -> data_out holds 01h; FIFO 0 stores 02h..05h; 06h is dropped; ovf_lanes[0]=1 when the macro is defined.
REQ-033 Scenario: lanes 1 and 3 each continuously non-empty, ready_in=1 -> lane_out alternates 1,3,1,3; lane 0 and lane 2 are never granted.
REQ-034 Scenario: ready_in toggles 1,0,1,0 while lane 2 streams AAh, BBh, 88h -> each byte appears exactly once and in order, and data_out is stable during each ready_in=0 cycle.
REQ-035 Scenario: reset pulsed while FIFO 0 holds 3 bytes and valid_out=1 -> valid_out=0 and lanes_empty=1111b immediately; the next accepted byte 77h appears as the first output.
REQ-036 Scenario: lane 0 full, ready_in=1 and valid_rx0=1 with 99h on the same edge -> 99h is accepted, occupancy stays at DEPTH, and no overflow flag is set.

Source files
------------

// File: rtl/rx_lane_merger.sv
// Four-lane RX merger: per-lane byte FIFOs drained round-robin into one registered output stream.
// Optional MERGE_OVERFLOW_FLAG_EN adds ovf_lanes, a sticky per-lane flag for dropped bytes.

module rx_lane_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk_f,
  input  logic         reset,
  input  logic         i_wr,
  input  logic [W-1:0] i_din,
  input  logic         i_rd,
  output logic [W-1:0] o_dout,
  output logic         o_empty
`ifdef MERGE_OVERFLOW_FLAG_EN
  ,
  output logic         o_ovf
`endif
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_full, w_wr_ok;

  // A pop on the same edge frees the slot, so a full FIFO still takes the write.
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_wr_ok = i_wr & (~w_full | i_rd);
  assign o_empty = (r_count == '0);
  assign o_dout  = r_mem[r_rptr];

  always_ff @(posedge clk_f) begin
    if (w_wr_ok) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
      if (i_rd)    r_rptr <= r_rptr + 1'b1;
      case ({w_wr_ok, i_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MERGE_OVERFLOW_FLAG_EN
  logic r_ovf;
  always_ff @(posedge clk_f or posedge reset) begin
    if (reset)                 r_ovf <= 1'b0;
    else if (i_wr & ~w_wr_ok)  r_ovf <= 1'b1;
  end
  assign o_ovf = r_ovf;
`endif
endmodule

module rx_lane_merger #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk_f,
  input  logic         reset,
  input  logic [W-1:0] data_rx0,
  input  logic [W-1:0] data_rx1,
  input  logic [W-1:0] data_rx2,
  input  logic [W-1:0] data_rx3,
  input  logic         valid_rx0,
  input  logic         valid_rx1,
  input  logic         valid_rx2,
  input  logic         valid_rx3,
  input  logic         ready_in,
  output logic [W-1:0] data_out,
  output logic         valid_out,
  output logic [1:0]   lane_out,
  output logic [3:0]   lanes_empty
`ifdef MERGE_OVERFLOW_FLAG_EN
  ,
  output logic [3:0]   ovf_lanes
`endif
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][W-1:0] w_din, w_dout;
  logic [NUM_LANES-1:0]        w_vld, w_rd, w_empty;
  logic [1:0]                  w_gnt, w_idx;
  logic                        w_gnt_vld, w_load, w_pop;

  logic [W-1:0] r_data;
  logic         r_valid;
  logic [1:0]   r_lane, r_last_grant;

  assign w_din = {data_rx3, data_rx2, data_rx1, data_rx0};
  assign w_vld = {valid_rx3, valid_rx2, valid_rx1, valid_rx0};

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      assign w_rd[g] = w_pop & (w_gnt == 2'(g));
      rx_lane_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk_f   (clk_f),
        .reset   (reset),
        .i_wr    (w_vld[g]),
        .i_din   (w_din[g]),
        .i_rd    (w_rd[g]),
        .o_dout  (w_dout[g]),
        .o_empty (w_empty[g])
`ifdef MERGE_OVERFLOW_FLAG_EN
        ,
        .o_ovf   (ovf_lanes[g])
`endif
      );
    end
  endgenerate

  // Search order starts one past the last grant; offset 4 wraps back onto last_grant itself.
  always_comb begin
    w_gnt     = r_last_grant;
    w_gnt_vld = 1'b0;
    w_idx     = r_last_grant;
    for (int i = 1; i <= NUM_LANES; i++) begin
      w_idx = r_last_grant + 2'(i);
      if (!w_gnt_vld && !w_empty[w_idx]) begin
        w_gnt     = w_idx;
        w_gnt_vld = 1'b1;
      end
    end
  end

  assign w_load = ~r_valid | ready_in;
  assign w_pop  = w_load & w_gnt_vld;

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_lane       <= 2'd0;
      r_last_grant <= 2'd3;
    end else if (w_load) begin
      if (w_gnt_vld) begin
        r_data       <= w_dout[w_gnt];
        r_lane       <= w_gnt;
        r_valid      <= 1'b1;
        r_last_grant <= w_gnt;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_out    = r_data;
  assign valid_out   = r_valid;
  assign lane_out    = r_lane;
  assign lanes_empty = w_empty;
endmodule

// File: tb/tb_rx_lane_merger.sv
// Self-checking bench for rx_lane_merger: vector table, corner sequences, random traffic vs queue model.

module tb_rx_lane_merger;
  localparam int DEPTH = 4;

  logic       clk_f = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_rx0 = '0, data_rx1 = '0, data_rx2 = '0, data_rx3 = '0;
  logic       valid_rx0 = 1'b0, valid_rx1 = 1'b0, valid_rx2 = 1'b0, valid_rx3 = 1'b0;
  logic       ready_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] lane_out;
  logic [3:0] lanes_empty;
`ifdef MERGE_OVERFLOW_FLAG_EN
  logic [3:0] ovf_lanes;
`endif

  rx_lane_merger #(.DEPTH(DEPTH), .W(8)) dut (
    .clk_f       (clk_f),
    .reset       (reset),
    .data_rx0    (data_rx0),
    .data_rx1    (data_rx1),
    .data_rx2    (data_rx2),
    .data_rx3    (data_rx3),
    .valid_rx0   (valid_rx0),
    .valid_rx1   (valid_rx1),
    .valid_rx2   (valid_rx2),
    .valid_rx3   (valid_rx3),
    .ready_in    (ready_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .lane_out    (lane_out),
    .lanes_empty (lanes_empty)
`ifdef MERGE_OVERFLOW_FLAG_EN
    ,
    .ovf_lanes   (ovf_lanes)
`endif
  );

  always #5 clk_f = ~clk_f;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per lane, output register and round-robin pointer.
  typedef logic [7:0] bq_t[$];
  bq_t        mq[4];
  logic       m_valid;
  logic [7:0] m_data;
  int         m_lane, m_last;
`ifdef MERGE_OVERFLOW_FLAG_EN
  logic [3:0] m_ovf;
`endif

  task automatic model_reset();
    for (int n = 0; n < 4; n++) mq[n].delete();
    m_valid = 1'b0; m_data = '0; m_lane = 0; m_last = 3;
`ifdef MERGE_OVERFLOW_FLAG_EN
    m_ovf = '0;
`endif
  endtask

  task automatic model_step(input logic [3:0] v, input logic [31:0] d, input logic r);
    int popl = -1;
    if (!m_valid || r) begin
      for (int k = 1; k <= 4; k++) begin
        int l = (m_last + k) % 4;
        if (popl < 0 && mq[l].size() > 0) popl = l;
      end
      if (popl >= 0) begin
        m_data = mq[popl].pop_front();
        m_lane = popl; m_valid = 1'b1; m_last = popl;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int n = 0; n < 4; n++) begin
      if (v[n]) begin
        if (mq[n].size() < DEPTH) mq[n].push_back(d[n*8 +: 8]);
`ifdef MERGE_OVERFLOW_FLAG_EN
        else m_ovf[n] = 1'b1;
`endif
      end
    end
  endtask

  task automatic chk_model(input string tag);
    logic [3:0] e;
    for (int n = 0; n < 4; n++) e[n] = (mq[n].size() == 0);
    chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, m_valid});
    if (m_valid) begin
      chk({tag, ".data"}, {24'd0, data_out}, {24'd0, m_data});
      chk({tag, ".lane"}, {30'd0, lane_out}, m_lane);
    end
    chk({tag, ".empty"}, {28'd0, lanes_empty}, {28'd0, e});
`ifdef MERGE_OVERFLOW_FLAG_EN
    chk({tag, ".ovf"}, {28'd0, ovf_lanes}, {28'd0, m_ovf});
`endif
  endtask

  // Called at posedge+1; drives inputs, takes one edge, returns at posedge+1.
  task automatic cyc(input logic [3:0] v, input logic [31:0] d, input logic r);
    {valid_rx3, valid_rx2, valid_rx1, valid_rx0} = v;
    {data_rx3, data_rx2, data_rx1, data_rx0} = d;
    ready_in = r;
    @(posedge clk_f);
    model_step(v, d, r);
    #1;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    {valid_rx3, valid_rx2, valid_rx1, valid_rx0} = '0;
    ready_in = 1'b0;
    #1;
    model_reset();
    chk("rst.valid", {31'd0, valid_out}, 32'd0);
    chk("rst.data",  {24'd0, data_out},  32'd0);
    chk("rst.lane",  {30'd0, lane_out},  32'd0);
    chk("rst.empty", {28'd0, lanes_empty}, 32'hF);
`ifdef MERGE_OVERFLOW_FLAG_EN
    chk("rst.ovf", {28'd0, ovf_lanes}, 32'd0);
`endif
    @(posedge clk_f);
    @(posedge clk_f);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic        r;
    logic        ev;
    logic [7:0]  ed;
    logic [1:0]  el;
    logic [3:0]  ee;
  } vec_t;
  vec_t tbl[17];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] got[$];
    logic [7:0] prev;
    logic [7:0] exp_b[4];
    logic       rr;
    int         k;

    // Four-lane burst, then lane 0 overrun under back-pressure and drain.
    tbl[0]  = '{4'hF, 32'hCCEEDDFF, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000};
    tbl[1]  = '{4'h0, 32'h0,        1'b1, 1'b1, 8'hFF, 2'd0, 4'b0001};
    tbl[2]  = '{4'h0, 32'h0,        1'b1, 1'b1, 8'hDD, 2'd1, 4'b0011};
    tbl[3]  = '{4'h0, 32'h0,        1'b1, 1'b1, 8'hEE, 2'd2, 4'b0111};
    tbl[4]  = '{4'h0, 32'h0,        1'b1, 1'b1, 8'hCC, 2'd3, 4'b1111};
    tbl[5]  = '{4'h0, 32'h0,        1'b1, 1'b0, 8'h00, 2'd0, 4'b1111};
    tbl[6]  = '{4'h1, 32'h01,       1'b0, 1'b0, 8'h00, 2'd0, 4'b1110};
    tbl[7]  = '{4'h1, 32'h02,       1'b0, 1'b1, 8'h01, 2'd0, 4'b1110};
    tbl[8]  = '{4'h1, 32'h03,       1'b0, 1'b1, 8'h01, 2'd0, 4'b1110};
    tbl[9]  = '{4'h1, 32'h04,       1'b0, 1'b1, 8'h01, 2'd0, 4'b1110};
    tbl[10] = '{4'h1, 32'h05,       1'b0, 1'b1, 8'h01, 2'd0, 4'b1110};
    tbl[11] = '{4'h1, 32'h06,       1'b0, 1'b1, 8'h01, 2'd0, 4'b1110};
    tbl[12] = '{4'h0, 32'h0,        1'b1, 1'b1, 8'h02, 2'd0, 4'b1110};
    tbl[13] = '{4'h0, 32'h0,        1'b1, 1'b1, 8'h03, 2'd0, 4'b1110};
    tbl[14] = '{4'h0, 32'h0,        1'b1, 1'b1, 8'h04, 2'd0, 4'b1110};
    tbl[15] = '{4'h0, 32'h0,        1'b1, 1'b1, 8'h05, 2'd0, 4'b1111};
    tbl[16] = '{4'h0, 32'h0,        1'b1, 1'b0, 8'h00, 2'd0, 4'b1111};

    @(posedge clk_f); #1;
    do_reset();

    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d.valid", i), {31'd0, valid_out}, {31'd0, tbl[i].ev});
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d.data", i), {24'd0, data_out}, {24'd0, tbl[i].ed});
        chk($sformatf("tbl%0d.lane", i), {30'd0, lane_out}, {30'd0, tbl[i].el});
      end
      chk($sformatf("tbl%0d.empty", i), {28'd0, lanes_empty}, {28'd0, tbl[i].ee});
`ifdef MERGE_OVERFLOW_FLAG_EN
      if (i == 11) chk("tbl.ovf_after_drop", {28'd0, ovf_lanes}, 32'h1);
`endif
    end

    // Lanes 1 and 3 always busy: grants alternate and never touch 0 or 2.
    do_reset();
    for (k = 0; k < 10; k++) begin
      cyc(4'b1010, {8'h30 + 8'(k), 8'h00, 8'h10 + 8'(k), 8'h00}, 1'b1);
      chk_model("rr");
      if (k >= 1) begin
        chk("rr.valid", {31'd0, valid_out}, 32'd1);
        chk("rr.lane", {30'd0, lane_out}, (k % 2 == 1) ? 32'd1 : 32'd3);
      end
    end

    // ready_in toggling while lane 2 streams three bytes.
    do_reset();
    got.delete();
    for (k = 0; k < 8; k++) begin
      rr = (k % 2 == 0);
      if (valid_out && rr) got.push_back(data_out);
      prev = data_out;
      case (k)
        0: cyc(4'b0100, 32'h00AA0000, rr);
        1: cyc(4'b0100, 32'h00BB0000, rr);
        2: cyc(4'b0100, 32'h00880000, rr);
        default: cyc(4'b0000, 32'h0, rr);
      endcase
      if (!rr && k >= 2) chk("tog.hold", {24'd0, data_out}, {24'd0, prev});
      chk_model("tog");
    end
    chk("tog.count", got.size(), 32'd3);
    exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'h88;
    for (int i = 0; i < 3 && i < got.size(); i++)
      chk($sformatf("tog.byte%0d", i), {24'd0, got[i]}, {24'd0, exp_b[i]});

    // Reset mid-transfer with three bytes buffered and an output held.
    do_reset();
    for (k = 1; k <= 4; k++) cyc(4'b0001, 32'(k), 1'b0);
    chk("mid.pre_valid", {31'd0, valid_out}, 32'd1);
    chk("mid.pre_empty", {31'd0, lanes_empty[0]}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("mid.valid", {31'd0, valid_out}, 32'd0);
    chk("mid.empty", {28'd0, lanes_empty}, 32'hF);
    chk("mid.data", {24'd0, data_out}, 32'd0);
    @(posedge clk_f); #1;
    reset = 1'b0;
    cyc(4'b0001, 32'h77, 1'b1);
    cyc(4'b0000, 32'h0, 1'b1);
    chk("mid.first_valid", {31'd0, valid_out}, 32'd1);
    chk("mid.first_data", {24'd0, data_out}, 32'h77);
    chk_model("mid");

    // Full lane 0 written and popped on the same edge.
    do_reset();
    for (k = 0; k < 5; k++) cyc(4'b0001, 32'h10 + 32'(k), 1'b0);
    cyc(4'b0001, 32'h99, 1'b1);
    chk("full.data", {24'd0, data_out}, 32'h11);
    chk("full.empty0", {31'd0, lanes_empty[0]}, 32'd0);
`ifdef MERGE_OVERFLOW_FLAG_EN
    chk("full.ovf", {28'd0, ovf_lanes}, 32'd0);
`endif
    exp_b[0] = 8'h12; exp_b[1] = 8'h13; exp_b[2] = 8'h14; exp_b[3] = 8'h99;
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0000, 32'h0, 1'b1);
      chk($sformatf("full.drain%0d", i), {23'd0, valid_out, data_out}, {23'd0, 1'b1, exp_b[i]});
    end
    cyc(4'b0000, 32'h0, 1'b1);
    chk("full.done", {31'd0, valid_out}, 32'd0);

    // Random traffic against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] v;
      logic       r;
      if (i % 750 == 749) do_reset();
      for (int n = 0; n < 4; n++) v[n] = ($urandom_range(0, 99) < ((i < 1500) ? 30 : 60));
      r = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
      cyc(v, $urandom, r);
      chk_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
